conv1d_window_feeder: RTL and testbench
=======================================

# conv1d_window_feeder

Upstream stage of the `conv1d` dot-product engine. Accepts a serial stream of signed samples through a valid/ready handshake, holds a `rows`-deep sliding window, and presents it on `A`, with the kernel loaded serially into `kern`. It also delays the window-valid strobe to line up with the 2-cycle `conv1d` result latency, so downstream logic knows when `out` is meaningful.

## Interface
- `bw`, 8: sample and coefficient width, two's complement.
- `rows`, 8: window depth and kernel taps; a power of two, at least 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `kern_start` in 1: one-cycle pulse; restarts kernel load from any state.
- `kern_valid` in 1: coefficient strobe.
- `kern_data` in `bw`: coefficient value.
- `kern_ready` out 1: high only in KLOAD.
- `in_valid` in 1: sample strobe.
- `in_data` in `bw`: sample value.
- `in_last` in 1: marks the final sample of a sequence.
- `in_ready` out 1: sample accepted on an edge where `in_valid && in_ready`.
- `A` out `rows*bw`: window; slot i at `[bw*i +: bw]` holds x[n-i], slot 0 newest.
- `kern` out `rows*bw`: coefficient k at `[bw*k +: bw]`, first loaded is k=0.
- `win_valid` out 1: `A` holds a new full window this cycle (one-cycle pulse).
- `win_last` out 1: qualifies `win_valid`; the window ends a sequence.
- `res_valid`, `res_last` out 1: `win_valid` / `win_last` delayed 2 cycles; aligned with `conv1d.out`.

## Operation
- States: KLOAD, FILL, RUN. Reset state is KLOAD.
- Counters: `k_cnt` and `f_cnt`, each `$clog2(rows)+1` bits.
- KLOAD:
  - `kern_ready`=1, `in_ready`=0.
  - Each `kern_valid` cycle writes `kern_data` to slot `k_cnt` and increments `k_cnt`.
  - On the `rows`-th coefficient: clear `k_cnt` and `f_cnt`, go to FILL.
- `in_ready` = (state != KLOAD) && !`kern_start`, combinational.
- Accepted sample, FILL or RUN:
  - Shift slot i <= slot i-1; slot 0 <= `in_data`.
  - No arithmetic; samples pass through bit-exact.
- FILL:
  - `f_cnt` increments per accept.
  - The accept that brings the count to `rows` sets `win_valid` on the next cycle and moves the FSM to RUN.
- RUN: every accept sets `win_valid` on the next cycle.
- `in_last` accepted:
  - If this accept completes a window (RUN, or the `rows`-th FILL accept), assert `win_last` with that `win_valid`.
  - If the window was not yet full (FILL), emit nothing and discard the partial window.
  - In both cases, return to FILL with `f_cnt`=0. The window is zeroed on the cycle after the emitted `win_valid`, or immediately if nothing was emitted.
- `kern_start`, any state:
  - Go to KLOAD, clear `k_cnt`, `f_cnt` and the window.
  - Takes priority over `kern_valid` and `in_valid` in the same cycle; neither is consumed.
  - Pending `res_valid` pipeline entries still drain.
- `kern` holds its value outside KLOAD. During reload, slots update one at a time.
- Reset mid-operation: all registers cleared at once. No sample is consumed on the reset edge.

## Timing
- Reset values:
  - `A`=0, `kern`=0.
  - `win_valid`=0, `win_last`=0, `res_valid`=0, `res_last`=0.
  - `kern_ready`=1, `in_ready`=0.
  - State KLOAD, counters 0.
- Accept at edge t:
  - `A` and `win_valid` valid in cycle t+1.
  - `res_valid` in cycle t+3, when `conv1d.out` holds that window's sum.
- Throughput: one window per cycle with back-to-back `in_valid`.
- No downstream stall; `A` changes only on an accept, a `kern_start`, or a post-last clear.
- `kern_ready` and `in_ready` depend only on state and `kern_start`.

## Test plan
- Reset: assert `rst` mid-cycle with `clk` idle → all outputs 0 asynchronously, `kern_ready`=1, `in_ready`=0.
- Load kern 1..8, then stream samples 1..8 back-to-back:
  - `win_valid` high exactly one cycle after the 8th accept.
  - `A` slot0=8, slot7=1; `kern` slot k = k+1.
  - `res_valid` 2 cycles later; a `conv1d` model gives 120.
- Continue with sample 9 → next cycle `A` slot0=9, slot7=2, `win_valid`=1.
- Sample 10 with `in_last` → `win_valid`=`win_last`=1. Next cycle:
  - `A`=0.
  - The next 7 samples produce no `win_valid`.
  - The 8th produces a window with `res_last`=0.
- Send 3 samples, the third with `in_last` → no `win_valid`, `f_cnt` back to 0. Also send `in_data`=0x80 and `kern_data`=0xFF → values appear unmodified in `A` and `kern`.
- `kern_start` together with `in_valid` in RUN:
  - Sample not accepted, `in_ready`=0.
  - Reload kern 2×8 and refill; the first window is at the 8th new accept.
- Separately, `rst` pulse mid-RUN → immediate clear; no `res_valid` afterwards.

Source files
------------

// File: rtl/conv1d_window_feeder.sv
// Sliding-window and kernel feeder for the conv1d dot-product engine.
// Also delays the window strobe by the engine's 2-cycle latency.
module conv1d_window_feeder #(
  parameter int unsigned bw   = 8,
  parameter int unsigned rows = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 kern_start,
  input  logic                 kern_valid,
  input  logic [bw-1:0]        kern_data,
  output logic                 kern_ready,
  input  logic                 in_valid,
  input  logic [bw-1:0]        in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [rows*bw-1:0]   A,
  output logic [rows*bw-1:0]   kern,
  output logic                 win_valid,
  output logic                 win_last,
  output logic                 res_valid,
  output logic                 res_last
);

  localparam int unsigned CW = $clog2(rows) + 1;
  localparam int unsigned IW = $clog2(rows);
  localparam int unsigned AW = rows * bw;

  typedef enum logic [1:0] {KLOAD, FILL, RUN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   k_cnt, k_nxt;
  logic [CW-1:0]   f_cnt, f_nxt;
  logic [AW-1:0]   win, win_nxt;
  logic [AW-1:0]   kern_r, kern_nxt;
  logic            wv_nxt, wl_nxt;
  logic            clr_pend, clr_nxt;
  logic            full;
  logic            rv_d1, rl_d1;

  assign kern_ready = (state == KLOAD) && !kern_start;
  assign in_ready   = (state != KLOAD) && !kern_start;
  assign A          = win;
  assign kern       = kern_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= KLOAD;
    else     state <= state_nxt;
  end

  // Next state plus all datapath updates; kern_start overrides everything.
  always_comb begin
    state_nxt = state;
    k_nxt     = k_cnt;
    f_nxt     = f_cnt;
    win_nxt   = win;
    kern_nxt  = kern_r;
    wv_nxt    = 1'b0;
    wl_nxt    = 1'b0;
    clr_nxt   = 1'b0;
    full      = (state == RUN) || (f_cnt == CW'(rows - 1));
    if (kern_start) begin
      state_nxt = KLOAD;
      k_nxt     = '0;
      f_nxt     = '0;
      win_nxt   = '0;
    end else begin
      // A window emitted with in_last is wiped one cycle after it was shown.
      if (clr_pend) win_nxt = '0;
      case (state)
        KLOAD: begin
          if (kern_valid) begin
            kern_nxt[bw*k_cnt[IW-1:0] +: bw] = kern_data;
            k_nxt = k_cnt + CW'(1);
            if (k_cnt == CW'(rows - 1)) begin
              k_nxt     = '0;
              f_nxt     = '0;
              state_nxt = FILL;
            end
          end
        end
        FILL, RUN: begin
          if (in_valid) begin
            win_nxt = {win_nxt[AW-bw-1:0], in_data};
            if (full) begin
              wv_nxt = 1'b1;
              wl_nxt = in_last;
            end
            if (in_last) begin
              state_nxt = FILL;
              f_nxt     = '0;
              if (full) clr_nxt = 1'b1;
              else      win_nxt = '0;
            end else if (state == FILL) begin
              f_nxt = f_cnt + CW'(1);
              if (full) state_nxt = RUN;
            end
          end
        end
        default: state_nxt = KLOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_cnt     <= '0;
      f_cnt     <= '0;
      win       <= '0;
      kern_r    <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      clr_pend  <= 1'b0;
      rv_d1     <= 1'b0;
      rl_d1     <= 1'b0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
    end else begin
      k_cnt     <= k_nxt;
      f_cnt     <= f_nxt;
      win       <= win_nxt;
      kern_r    <= kern_nxt;
      win_valid <= wv_nxt;
      win_last  <= wl_nxt;
      clr_pend  <= clr_nxt;
      rv_d1     <= win_valid;
      rl_d1     <= win_last;
      res_valid <= rv_d1;
      res_last  <= rl_d1;
    end
  end

endmodule

// File: tb/tb_conv1d_window_feeder.sv
// Scoreboard bench for conv1d_window_feeder: stimulus pushes expected windows,
// a negedge monitor pops and compares on win_valid / res_valid.
module tb_conv1d_window_feeder;

  localparam int unsigned BW   = 8;
  localparam int unsigned ROWS = 8;
  localparam int unsigned AW   = BW * ROWS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          kern_start = 1'b0, kern_valid = 1'b0;
  logic [BW-1:0] kern_data = '0;
  logic          kern_ready;
  logic          in_valid = 1'b0, in_last = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          in_ready;
  logic [AW-1:0] A, kern;
  logic          win_valid, win_last, res_valid, res_last;

  conv1d_window_feeder #(.bw(BW), .rows(ROWS)) dut (
    .clk(clk), .rst(rst),
    .kern_start(kern_start), .kern_valid(kern_valid), .kern_data(kern_data),
    .kern_ready(kern_ready),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .A(A), .kern(kern),
    .win_valid(win_valid), .win_last(win_last),
    .res_valid(res_valid), .res_last(res_last)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] a; logic [AW-1:0] k; logic last; } win_t;
  typedef struct packed { logic [31:0] sum; logic last; } res_t;
  typedef struct packed { logic [31:0] sum; logic [31:0] cyc; } act_t;

  win_t win_q[$];
  res_t res_q[$];
  act_t act_q[$];

  int checks = 0, failures = 0, cyc = 0;
  logic [AW-1:0] mw = '0, mk = '0;
  int mf = 0, kc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int dot(input logic [AW-1:0] a, input logic [AW-1:0] k);
    int s;
    s = 0;
    for (int i = 0; i < ROWS; i++) s += $signed(a[BW*i +: BW]) * $signed(k[BW*i +: BW]);
    return s;
  endfunction

  // Monitor: compare every presented window and result against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (win_valid) begin
        if (win_q.size() == 0) chk("unexpected_win_valid", 64'(win_valid), 64'd0);
        else begin
          win_t e;
          act_t a;
          e = win_q.pop_front();
          chk("win_A", A, e.a);
          chk("win_kern", kern, e.k);
          chk("win_last", 64'(win_last), 64'(e.last));
          a.sum = dot(A, kern);
          a.cyc = cyc;
          act_q.push_back(a);
        end
      end
      if (res_valid) begin
        if (act_q.size() == 0 || res_q.size() == 0)
          chk("unexpected_res_valid", 64'(res_valid), 64'd0);
        else begin
          act_t a;
          res_t e;
          a = act_q.pop_front();
          e = res_q.pop_front();
          chk("res_latency", 64'(cyc - int'(a.cyc)), 64'd2);
          chk("res_sum", 64'(a.sum), 64'(e.sum));
          chk("res_last", 64'(res_last), 64'(e.last));
        end
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; kern_valid = 1'b0; kern_start = 1'b0;
  endtask

  task automatic load(input logic [BW-1:0] d);
    @(negedge clk);
    kern_valid = 1'b1; kern_data = d;
    #1;
    chk("kern_ready_kload", 64'(kern_ready), 64'd1);
    chk("in_ready_kload", 64'(in_ready), 64'd0);
    @(posedge clk);
    mk[BW*kc +: BW] = d;
    kc++;
  endtask

  task automatic send(input logic [BW-1:0] d, input logic last);
    win_t w;
    res_t r;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last; kern_valid = 1'b0;
    #1;
    chk("in_ready_stream", 64'(in_ready), 64'd1);
    @(posedge clk);
    mw = {mw[AW-BW-1:0], d};
    mf++;
    if (mf >= ROWS) begin
      w.a = mw; w.k = mk; w.last = last;
      r.sum = dot(mw, mk); r.last = last;
      win_q.push_back(w);
      res_q.push_back(r);
    end
    if (last) begin
      mf = 0;
      mw = '0;
    end
  endtask

  initial begin
    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    chk("rst_A", A, '0);
    chk("rst_kern", kern, '0);
    chk("rst_win", 64'({win_valid, win_last, res_valid, res_last}), 64'd0);
    chk("rst_kern_ready", 64'(kern_ready), 64'd1);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 1; i <= 8; i++) load(BW'(i));
    idle();
    chk("kern_slot7", 64'(kern[BW*7 +: BW]), 64'd8);

    for (int i = 1; i <= 8; i++) send(BW'(i), 1'b0);
    @(negedge clk); #1;
    in_valid = 1'b0;
    chk("first_win_valid", 64'(win_valid), 64'd1);
    chk("first_A_slot0", 64'(A[7:0]), 64'd8);
    chk("first_A_slot7", 64'(A[63:56]), 64'd1);
    chk("first_sum_model", 64'(dot(A, kern)), 64'd120);

    send(8'd9, 1'b0);
    send(8'd10, 1'b1);
    idle();
    @(negedge clk); #1;
    chk("post_last_A_zero", A, '0);

    for (int i = 11; i <= 18; i++) send(BW'(i), 1'b0);
    send(8'h80, 1'b1);
    idle();

    // Partial window discarded; raw 0x80 passes untouched
    send(8'h80, 1'b0);
    #1 chk("A_raw_0x80", 64'(A[7:0]), 64'h80);
    send(8'd1, 1'b0);
    send(8'd2, 1'b1);
    #1 chk("partial_A_zero", A, '0);

    send(8'hfd, 1'b0);
    for (int i = 1; i <= 7; i++) send(BW'(i * 3), 1'b0);
    send(8'h7f, 1'b0);

    // kern_start beats a simultaneous sample
    @(negedge clk);
    kern_start = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0;
    #1 chk("in_ready_kern_start", 64'(in_ready), 64'd0);
    @(posedge clk);
    mw = '0; mf = 0; kc = 0;
    idle();
    #1 chk("kern_start_A_zero", A, '0);

    load(8'hff);
    for (int i = 1; i < 8; i++) load(8'd2);
    idle();
    chk("kern_raw_0xff", 64'(kern[7:0]), 64'hff);
    for (int i = 1; i <= 8; i++) send(BW'(i + 20), 1'b0);
    send(8'd40, 1'b0);

    // Reset mid-RUN kills pending results
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_A", A, '0);
    chk("midrun_rst_kern", kern, '0);
    chk("midrun_rst_strobes", 64'({win_valid, res_valid}), 64'd0);
    res_q.delete();
    act_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) idle();

    chk("win_q_empty", 64'(win_q.size()), 64'd0);
    chk("res_q_empty", 64'(res_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
